// File: rtl/score_pkg.sv
// score_pkg -- shared definitions for the score tracker slice.
//   trk_state_e   : tracker state encoding seen by the VGA renderer / LEDs
//   DEFAULT_LIVES : lives granted at each new game
//   SCORE_MAX     : largest two-digit decimal score
//   BCD_MAX       : SCORE_MAX in packed BCD
//   to_bcd()      : elaboration-time decimal -> packed BCD conversion
//   bcd_inc()     : two-digit packed BCD increment (caller keeps it below 99)
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } trk_state_e;

    localparam int          DEFAULT_LIVES = 3;
    localparam int          SCORE_MAX     = 99;
    localparam logic [7:0]  BCD_MAX       = 8'h99;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
            r[3:0] = 4'd0;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_tracker_bcd2_counter.sv
// bcd2_counter -- two-digit packed BCD up-counter with saturation.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one when below the ceiling
//   sat   : saturation ceiling, packed BCD
//   count : current value, packed BCD (tens in [7:4])
module bcd2_counter
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] sat,
    output logic [7:0] count
);

    // Packed BCD orders the same as binary, so a plain compare finds the ceiling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= 8'h00;
        else if (clr)
            count <= 8'h00;
        else if (inc && (count < sat))
            count <= bcd_inc(count);
    end

endmodule

// File: rtl/score_tracker.sv
// score_tracker -- score / lives / best-score bookkeeping for the guessing game.
//   clk, reset    : clock; asynchronous active-low reset
//   new_game      : pulse, start or restart a game (beats correct/wrong)
//   correct_pulse : pulse, guess correct (ignored if wrong_pulse also high)
//   wrong_pulse   : pulse, guess wrong, costs one life
//   score_bcd     : current score, packed BCD
//   best_bcd      : best finished-game score since reset, packed BCD
//   lives         : remaining lives
//   game_over     : high while in OVER
//   new_best      : one-cycle pulse after best_bcd was raised
//   trk_state     : IDLE=0 / PLAY=1 / OVER=2
// Build option: define SCORE_TRACKER_HIGH_SCORE_EN to build the best-score
// register; otherwise best_bcd and new_best are tied to zero.
module score_tracker
    import score_pkg::*;
#(
    parameter int MAX_LIVES = DEFAULT_LIVES,
    parameter int SAT_SCORE = SCORE_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       correct_pulse,
    input  logic       wrong_pulse,
    output logic [7:0] score_bcd,
    output logic [7:0] best_bcd,
    output logic [2:0] lives,
    output logic       game_over,
    output logic       new_best,
    output logic [1:0] trk_state
);

    localparam logic [7:0] SAT_BCD    = to_bcd(SAT_SCORE);
    localparam logic [2:0] LIVES_INIT = 3'(MAX_LIVES);

    trk_state_e state_q, state_d;
    logic [2:0] lives_q;
    logic       in_play, hit_wrong, hit_correct, game_end;

    // new_game overrides any guess pulse; a simultaneous correct+wrong is a wrong.
    assign in_play     = (state_q == PLAY) && !new_game;
    assign hit_wrong   = in_play && wrong_pulse;
    assign hit_correct = in_play && correct_pulse && !wrong_pulse;
    assign game_end    = hit_wrong && (lives_q == 3'd1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_game) state_d = PLAY;
            PLAY:    if (game_end) state_d = OVER;
            OVER:    if (new_game) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        trk_state = state_q;
        game_over = (state_q == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lives_q <= 3'd0;
        else if (new_game)
            lives_q <= LIVES_INIT;
        else if (hit_wrong)
            lives_q <= lives_q - 3'd1;
    end

    assign lives = lives_q;

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (new_game),
        .inc   (hit_correct),
        .sat   (SAT_BCD),
        .count (score_bcd)
    );

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    logic [7:0] best_q;
    logic       new_best_q;

    // Score cannot move on the ending edge (it is a wrong), so score_bcd is final.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q     <= 8'h00;
            new_best_q <= 1'b0;
        end else begin
            new_best_q <= 1'b0;
            if (game_end && (score_bcd > best_q)) begin
                best_q     <= score_bcd;
                new_best_q <= 1'b1;
            end
        end
    end

    assign best_bcd = best_q;
    assign new_best = new_best_q;
`else
    assign best_bcd = 8'h00;
    assign new_best = 1'b0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
module tb_score_tracker;

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif
    localparam int MAXL = 3;
    localparam int SAT  = 99;

    logic       clk = 1'b0;
    logic       reset, new_game, correct_pulse, wrong_pulse;
    logic [7:0] score_bcd, best_bcd;
    logic [2:0] lives;
    logic       game_over, new_best;
    logic [1:0] trk_state;

    int  errors = 0;
    int  checks = 0;
    bit  run    = 1'b0;

    // Behavioural model: plain decimal score and integer lives
    int  m_state, m_score, m_lives, m_best;
    bit  m_nb;

    score_tracker #(.MAX_LIVES(MAXL), .SAT_SCORE(SAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .new_game      (new_game),
        .correct_pulse (correct_pulse),
        .wrong_pulse   (wrong_pulse),
        .score_bcd     (score_bcd),
        .best_bcd      (best_bcd),
        .lives         (lives),
        .game_over     (game_over),
        .new_best      (new_best),
        .trk_state     (trk_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= 0; m_score <= 0; m_lives <= 0; m_best <= 0; m_nb <= 1'b0;
        end else begin
            m_nb <= 1'b0;
            if (new_game) begin
                m_state <= 1; m_score <= 0; m_lives <= MAXL;
            end else if (m_state == 1) begin
                if (wrong_pulse) begin
                    m_lives <= m_lives - 1;
                    if (m_lives == 1) begin
                        m_state <= 2;
                        if (HS && m_score > m_best) begin
                            m_best <= m_score;
                            m_nb   <= 1'b1;
                        end
                    end
                end else if (correct_pulse && m_score < SAT) begin
                    m_score <= m_score + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m_score", score_bcd, bcd(m_score));
            chk("m_best", best_bcd, bcd(m_best));
            chk("m_lives", {5'd0, lives}, 8'(m_lives));
            chk("m_game_over", {7'd0, game_over}, {7'd0, (m_state == 2)});
            chk("m_new_best", {7'd0, new_best}, {7'd0, m_nb});
            chk("m_state", {6'd0, trk_state}, 8'(m_state));
        end
    end

    task automatic step(input logic ng, input logic c, input logic w);
        new_game = ng; correct_pulse = c; wrong_pulse = w;
        @(posedge clk); #1;
        new_game = 1'b0; correct_pulse = 1'b0; wrong_pulse = 1'b0;
    endtask

    task automatic play_game(input int n);
        step(1, 0, 0);
        repeat (n) step(0, 1, 0);
        repeat (MAXL) step(0, 0, 1);
    endtask

    initial begin
        reset = 1'b0; new_game = 1'b0; correct_pulse = 1'b0; wrong_pulse = 1'b0;
        #12;
        chk("rst_score", score_bcd, 8'h00);
        chk("rst_best", best_bcd, 8'h00);
        chk("rst_lives", {5'd0, lives}, 8'd0);
        chk("rst_go", {7'd0, game_over}, 8'd0);
        chk("rst_nb", {7'd0, new_best}, 8'd0);
        chk("rst_state", {6'd0, trk_state}, 8'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        run = 1'b1;

        // IDLE ignores guesses
        step(0, 1, 0); step(0, 0, 1);
        chk("idle_score", score_bcd, 8'h00);
        chk("idle_state", {6'd0, trk_state}, 8'd0);

        // new game, three correct
        step(1, 0, 0);
        repeat (3) step(0, 1, 0);
        chk("c3_score", score_bcd, 8'h03);
        chk("c3_lives", {5'd0, lives}, 8'd3);
        chk("c3_state", {6'd0, trk_state}, 8'd1);

        // BCD carry and saturation
        repeat (6) step(0, 1, 0);
        chk("s09", score_bcd, 8'h09);
        step(0, 1, 0);
        chk("s10", score_bcd, 8'h10);
        repeat (89) step(0, 1, 0);
        chk("s99", score_bcd, 8'h99);
        step(0, 1, 0);
        chk("s99_sat", score_bcd, 8'h99);

        // restart beats correct, and mid-game restart
        step(1, 0, 0);
        repeat (4) step(0, 1, 0);
        chk("s04", score_bcd, 8'h04);
        step(1, 1, 0);
        chk("ngc_score", score_bcd, 8'h00);
        chk("ngc_lives", {5'd0, lives}, 8'd3);
        repeat (4) step(0, 1, 0);
        step(1, 0, 0);
        chk("ng_score", score_bcd, 8'h00);
        chk("ng_lives", {5'd0, lives}, 8'd3);

        // correct+wrong together counts as wrong
        step(0, 1, 0);
        step(0, 1, 1);
        chk("cw_score", score_bcd, 8'h01);
        chk("cw_lives", {5'd0, lives}, 8'd2);

        // lives run out
        step(1, 0, 0);
        step(0, 0, 1); chk("l2", {5'd0, lives}, 8'd2);
        step(0, 0, 1); chk("l1", {5'd0, lives}, 8'd1);
        chk("l1_go", {7'd0, game_over}, 8'd0);
        step(0, 0, 1); chk("l0", {5'd0, lives}, 8'd0);
        chk("l0_go", {7'd0, game_over}, 8'd1);
        chk("l0_state", {6'd0, trk_state}, 8'd2);
        chk("l0_nb", {7'd0, new_best}, 8'd0);
        step(0, 1, 0);
        chk("over_ign", score_bcd, 8'h00);

        // best score tracking
        play_game(5);
        chk("g5_best", best_bcd, HS ? 8'h05 : 8'h00);
        chk("g5_nb", {7'd0, new_best}, {7'd0, HS});
        step(0, 0, 0);
        chk("g5_nb_drop", {7'd0, new_best}, 8'd0);
        play_game(7);
        chk("g7_best", best_bcd, HS ? 8'h07 : 8'h00);
        chk("g7_nb", {7'd0, new_best}, {7'd0, HS});
        step(0, 0, 0);
        chk("g7_nb_drop", {7'd0, new_best}, 8'd0);
        play_game(7);
        chk("g7b_best", best_bcd, HS ? 8'h07 : 8'h00);
        chk("g7b_nb", {7'd0, new_best}, 8'd0);

        // asynchronous reset mid-game
        step(1, 0, 0);
        step(0, 1, 0); step(0, 1, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_score", score_bcd, 8'h00);
        chk("ar_best", best_bcd, 8'h00);
        chk("ar_lives", {5'd0, lives}, 8'd0);
        chk("ar_state", {6'd0, trk_state}, 8'd0);
        chk("ar_go", {7'd0, game_over}, 8'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("ar_idle", {6'd0, trk_state}, 8'd0);
        step(1, 0, 0);
        chk("ar_ng_lives", {5'd0, lives}, 8'd3);
        chk("ar_ng_state", {6'd0, trk_state}, 8'd1);

        @(posedge clk); #1;
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter MAX_LIVES, default 3, the lives granted at each new game (legal range 1..7).
REQ-002 SHALL have parameter SAT_SCORE, default 99, the score saturation ceiling (legal range 1..99, BCD range).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_game  input  1  one-cycle pulse that starts or restarts a game.
REQ-006 SHALL have port correct_pulse  input  1  one-cycle pulse, guess judged correct by the game FSM.
REQ-007 SHALL have port wrong_pulse  input  1  one-cycle pulse, guess judged wrong by the game FSM.
REQ-008 SHALL have port score_bcd  output  8  current score, two BCD digits, tens in [7:4].
REQ-009 SHALL have port best_bcd  output  8  best score since reset, two BCD digits.
REQ-010 SHALL have port lives  output  3  remaining lives.
REQ-011 SHALL have port game_over  output  1  high while in state OVER.
REQ-012 SHALL have port new_best  output  1  one-cycle pulse when best_bcd is updated.
REQ-013 SHALL have port trk_state  output  2  encoded state, for the VGA renderer and LEDs.

Function
REQ-014 SHALL implement states IDLE=0, PLAY=1, OVER=2; encoding 3 unused, and it SHALL recover to IDLE.
REQ-015 IDLE: score and lives hold; new_game moves to PLAY.
REQ-016 Entering PLAY via new_game SHALL load score=0 and lives=MAX_LIVES on the same edge.
REQ-017 PLAY, correct_pulse only: score increments by 1 in BCD (09->10), saturating at SAT_SCORE.
REQ-018 PLAY, wrong_pulse only: lives decrements by 1; if lives was 1, lives becomes 0 and the state moves to OVER on the same edge.
REQ-019 correct_pulse and wrong_pulse in the same cycle SHALL be treated as wrong only.
REQ-020 new_game in any state SHALL take priority over correct and wrong pulses, including a restart mid-game from PLAY.
REQ-021 In IDLE and OVER, correct_pulse and wrong_pulse SHALL be ignored.
REQ-022 On the PLAY->OVER edge, if score_bcd > best_bcd, best_bcd SHALL load score_bcd and new_best SHALL pulse high for exactly the next cycle.
REQ-023 An equal score SHALL NOT update best_bcd or pulse new_best.
REQ-024 All outputs SHALL be registered; latency from an input pulse to the output change is 1 clock.
REQ-025 game_over SHALL be high exactly while trk_state==OVER.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, score_bcd=0x00, best_bcd=0x00, lives=0, game_over=0, new_best=0.
REQ-027 Reset deassertion SHALL leave the block in IDLE, waiting for new_game.

Configuration
REQ-028 With macro SCORE_TRACKER_HIGH_SCORE_EN defined, the best-score register and new_best logic SHALL be built as described.
REQ-029 Without SCORE_TRACKER_HIGH_SCORE_EN, best_bcd and new_best SHALL be constant 0 and no best-score register SHALL exist.

Structure
REQ-030 Shared package score_pkg SHALL hold the state encodings (IDLE, PLAY, OVER), the default lives value, and the BCD max constant.
REQ-031 SHALL instantiate sub-module bcd2_counter: a two-digit BCD counter with synchronous clear, increment enable and a saturation ceiling input.

Verification
REQ-032 Reset, new_game, 3 correct pulses -> score_bcd=0x03, lives=3, trk_state=PLAY.
REQ-033 From score 0x09, one correct pulse -> 0x10; from score 0x99, one correct pulse -> stays 0x99.
REQ-034 3 wrong pulses with MAX_LIVES=3 -> lives 2,1,0; game_over=1 on the cycle after the third pulse; later correct pulses are ignored.
REQ-035 First game ends at 0x05, second at 0x07 -> best_bcd=0x07 and new_best pulses once; a third game ending at 0x07 -> no pulse.
REQ-036 new_game and correct_pulse in the same cycle while in PLAY at score 0x04 -> score=0x00, lives=3; new_game mid-game -> same result.
REQ-037 reset asserted mid-PLAY between clock edges -> outputs clear immediately, without waiting for a clock edge.
